// File: rtl/adsr_poly.sv
// Time-multiplexed multi-voice ADSR envelope generator: one shared datapath
// walks every voice once per sample_tick and presents each updated level in turn.
module adsr_poly #(
    parameter int VOICES     = 4,
    parameter int ACC_BITS   = 16,
    parameter int CTRL_WIDTH = 4,
    parameter int VIDX_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_tick,
    input  logic [VOICES-1:0]     gate,
    input  logic [CTRL_WIDTH-1:0] a,
    input  logic [CTRL_WIDTH-1:0] d,
    input  logic [CTRL_WIDTH-1:0] s,
    input  logic [CTRL_WIDTH-1:0] r,
    input  logic                  hard_retrig,
    output logic                  env_valid,
    output logic [VIDX_BITS-1:0]  env_voice,
    output logic [ACC_BITS-1:0]   env_out,
    output logic                  busy,
    output logic                  overrun
);

    localparam logic [2:0] ST_OFF     = 3'd0;
    localparam logic [2:0] ST_ATTACK  = 3'd1;
    localparam logic [2:0] ST_DECAY   = 3'd2;
    localparam logic [2:0] ST_SUSTAIN = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    localparam logic [ACC_BITS:0]  ONE_C    = {{ACC_BITS{1'b0}}, 1'b1};
    localparam logic [ACC_BITS:0]  MAX_C    = {1'b0, {ACC_BITS{1'b1}}};
    localparam logic [VIDX_BITS:0] VOICES_C = (VIDX_BITS + 1)'(VOICES);
    localparam logic [VIDX_BITS:0] CNT_ONE  = {{VIDX_BITS{1'b0}}, 1'b1};

    // Power-of-two step; rates beyond the top exponent bottom out at a step of 1.
    function automatic logic [ACC_BITS:0] pow2_step(input logic [CTRL_WIDTH-1:0] x, input int top);
        logic [ACC_BITS:0] res;
        if (int'(x) <= top) begin
            res = ONE_C << (top - int'(x));
        end else begin
            res = ONE_C;
        end
        return res;
    endfunction

    logic [2:0]           state_r [VOICES];
    logic [ACC_BITS-1:0]  acc_r   [VOICES];
    logic [VOICES-1:0]    prev_gate_r;
    logic                 busy_r;
    logic [VIDX_BITS:0]   cnt_r;
    logic                 env_valid_r;
    logic [VIDX_BITS-1:0] env_voice_r;
    logic [ACC_BITS-1:0]  env_out_r;
    logic                 overrun_r;

    logic                 start_s;
    logic                 upd_s;
    logic [VIDX_BITS-1:0] vidx_s;
    logic [ACC_BITS:0]    attack_step_s;
    logic [ACC_BITS:0]    decay_step_s;
    logic [ACC_BITS:0]    release_step_s;
    logic [ACC_BITS:0]    sus_lvl_s;
    logic [ACC_BITS:0]    cur_acc_s;
    logic [ACC_BITS:0]    sum_s;
    logic [2:0]           cur_state_s;
    logic                 cur_gate_s;
    logic                 cur_prev_s;
    logic [2:0]           nxt_state_s;
    logic [ACC_BITS:0]    nxt_acc_s;

    assign start_s        = sample_tick & ~busy_r;
    assign upd_s          = start_s | (busy_r & (cnt_r < VOICES_C));
    assign attack_step_s  = pow2_step(a, ACC_BITS - 1);
    assign decay_step_s   = pow2_step(d, ACC_BITS - 3);
    assign release_step_s = pow2_step(r, ACC_BITS - 3);
    assign sus_lvl_s      = {1'b0, s, {(ACC_BITS - CTRL_WIDTH){1'b0}}};

    // Voice 0 is served in the tick cycle itself, later voices from the slot counter.
    always_comb begin
        if (busy_r) begin
            vidx_s = cnt_r[VIDX_BITS-1:0];
        end else begin
            vidx_s = {VIDX_BITS{1'b0}};
        end
    end

    assign cur_state_s = state_r[vidx_s];
    assign cur_acc_s   = {1'b0, acc_r[vidx_s]};
    assign cur_gate_s  = gate[vidx_s];
    assign cur_prev_s  = prev_gate_r[vidx_s];
    assign sum_s       = cur_acc_s + attack_step_s;

    // Shared envelope step for the voice in the current slot (one extra bit: no wrap).
    always_comb begin
        nxt_state_s = cur_state_s;
        nxt_acc_s   = cur_acc_s;
        if (cur_gate_s && !cur_prev_s) begin
            nxt_state_s = ST_ATTACK;
            if (hard_retrig) begin
                nxt_acc_s = {(ACC_BITS + 1){1'b0}};
            end else begin
                nxt_acc_s = cur_acc_s;
            end
        end else if (!cur_gate_s && ((cur_state_s == ST_ATTACK) || (cur_state_s == ST_DECAY) ||
                                     (cur_state_s == ST_SUSTAIN))) begin
            nxt_state_s = ST_RELEASE;
        end else begin
            case (cur_state_s)
                ST_ATTACK: begin
                    if (sum_s >= MAX_C) begin
                        nxt_acc_s   = MAX_C;
                        nxt_state_s = ST_DECAY;
                    end else begin
                        nxt_acc_s = sum_s;
                    end
                end
                ST_DECAY: begin
                    if (cur_acc_s <= (sus_lvl_s + decay_step_s)) begin
                        nxt_acc_s   = sus_lvl_s;
                        nxt_state_s = ST_SUSTAIN;
                    end else begin
                        nxt_acc_s = cur_acc_s - decay_step_s;
                    end
                end
                ST_SUSTAIN: nxt_acc_s = sus_lvl_s;
                ST_RELEASE: begin
                    if (cur_acc_s <= release_step_s) begin
                        nxt_acc_s   = {(ACC_BITS + 1){1'b0}};
                        nxt_state_s = ST_OFF;
                    end else begin
                        nxt_acc_s = cur_acc_s - release_step_s;
                    end
                end
                ST_OFF: nxt_acc_s = {(ACC_BITS + 1){1'b0}};
                default: begin
                    nxt_state_s = ST_OFF;
                    nxt_acc_s   = {(ACC_BITS + 1){1'b0}};
                end
            endcase
        end
    end

    // Sweep sequencing and overrun detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            cnt_r     <= {(VIDX_BITS + 1){1'b0}};
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= sample_tick & busy_r;
            if (!busy_r) begin
                if (sample_tick) begin
                    busy_r <= 1'b1;
                    cnt_r  <= CNT_ONE;
                end
            end else if (cnt_r < VOICES_C) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    // Per-voice state write-back for the active slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                state_r[v] <= ST_OFF;
                acc_r[v]   <= {ACC_BITS{1'b0}};
            end
            prev_gate_r <= {VOICES{1'b0}};
        end else if (upd_s) begin
            state_r[vidx_s]     <= nxt_state_s;
            acc_r[vidx_s]       <= nxt_acc_s[ACC_BITS-1:0];
            prev_gate_r[vidx_s] <= cur_gate_s;
        end
    end

    // Registered presentation of each voice update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            env_valid_r <= 1'b0;
            env_voice_r <= {VIDX_BITS{1'b0}};
            env_out_r   <= {ACC_BITS{1'b0}};
        end else begin
            env_valid_r <= upd_s;
            if (upd_s) begin
                env_voice_r <= vidx_s;
                env_out_r   <= nxt_acc_s[ACC_BITS-1:0];
            end
        end
    end

    assign env_valid = env_valid_r;
    assign env_voice = env_voice_r;
    assign env_out   = env_out_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_adsr_poly.sv
// Self-checking bench for adsr_poly: directed plan scenarios plus randomized
// sweeps compared against an integer envelope model.
module tb_adsr_poly;

    localparam int VOICES     = 4;
    localparam int ACC_BITS   = 16;
    localparam int CTRL_WIDTH = 4;
    localparam int VIDX_BITS  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  sample_tick;
    logic [VOICES-1:0]     gate;
    logic [CTRL_WIDTH-1:0] a, d, s, r;
    logic                  hard_retrig;
    logic                  env_valid;
    logic [VIDX_BITS-1:0]  env_voice;
    logic [ACC_BITS-1:0]   env_out;
    logic                  busy;
    logic                  overrun;

    adsr_poly #(
        .VOICES(VOICES), .ACC_BITS(ACC_BITS), .CTRL_WIDTH(CTRL_WIDTH), .VIDX_BITS(VIDX_BITS)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .gate(gate),
        .a(a), .d(d), .s(s), .r(r), .hard_retrig(hard_retrig),
        .env_valid(env_valid), .env_voice(env_voice), .env_out(env_out),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef enum int {M_OFF, M_ATT, M_DEC, M_SUS, M_REL} mstate_e;
    mstate_e m_state [VOICES];
    int      m_acc   [VOICES];
    bit      m_prev  [VOICES];

    int checks = 0;
    int errors = 0;
    logic [ACC_BITS-1:0] v0_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rate_step(int x, int top);
        return (x <= top) ? (1 << (top - x)) : 1;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_state[v] = M_OFF;
            m_acc[v]   = 0;
            m_prev[v]  = 1'b0;
        end
    endfunction

    // One envelope update of voice v using the inputs as they stand now.
    function automatic void model_slot(int v);
        bit g;
        int maxv, att, dst, rls, sus;
        g    = gate[v];
        maxv = (1 << ACC_BITS) - 1;
        att  = rate_step(int'(a), ACC_BITS - 1);
        dst  = rate_step(int'(d), ACC_BITS - 3);
        rls  = rate_step(int'(r), ACC_BITS - 3);
        sus  = int'(s) * (1 << (ACC_BITS - CTRL_WIDTH));
        if (g && !m_prev[v]) begin
            m_state[v] = M_ATT;
            if (hard_retrig) m_acc[v] = 0;
        end else if (!g && (m_state[v] == M_ATT || m_state[v] == M_DEC || m_state[v] == M_SUS)) begin
            m_state[v] = M_REL;
        end else begin
            case (m_state[v])
                M_ATT: if (m_acc[v] + att >= maxv) begin m_acc[v] = maxv; m_state[v] = M_DEC; end
                       else m_acc[v] = m_acc[v] + att;
                M_DEC: if (m_acc[v] <= sus + dst) begin m_acc[v] = sus; m_state[v] = M_SUS; end
                       else m_acc[v] = m_acc[v] - dst;
                M_SUS: m_acc[v] = sus;
                M_REL: if (m_acc[v] <= rls) begin m_acc[v] = 0; m_state[v] = M_OFF; end
                       else m_acc[v] = m_acc[v] - rls;
                default: m_acc[v] = 0;
            endcase
        end
        m_prev[v] = g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_slot(int v);
        model_slot(v);
        chk("valid", 32'(env_valid), 32'd1);
        chk("voice", 32'(env_voice), 32'(v));
        chk("level", 32'(env_out), 32'(m_acc[v]));
        chk("busy", 32'(busy), 32'd1);
        if (v == 0) v0_out = env_out;
    endtask

    // Full sweep from a tick in the current cycle, including the busy fall.
    task automatic sweep();
        sample_tick = 1'b1;
        for (int v = 0; v < VOICES; v++) begin
            step();
            sample_tick = 1'b0;
            check_slot(v);
        end
        step();
        chk("busy_fall", 32'(busy), 32'd0);
        chk("valid_fall", 32'(env_valid), 32'd0);
    endtask

    int exp_ad  [8] = '{0, 32768, 65535, 57343, 49151, 40959, 32768, 32768};
    int exp_rel [7] = '{32768, 24576, 16384, 8192, 0, 0, 0};

    initial begin
        rst = 1'b1; sample_tick = 1'b0; gate = '0;
        a = 4'd0; d = 4'd0; s = 4'd8; r = 4'd0; hard_retrig = 1'b0;
        model_reset();
        step(); step();
        chk("rst_valid", 32'(env_valid), 32'd0);
        chk("rst_voice", 32'(env_voice), 32'd0);
        chk("rst_out", 32'(env_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        step();

        // Attack then decay to sustain.
        gate[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sweep();
            chk("attack_decay", 32'(v0_out), 32'(exp_ad[i]));
        end

        // Release to OFF.
        gate[0] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            sweep();
            chk("release", 32'(v0_out), 32'(exp_rel[i]));
        end

        // Second tick while busy: overrun pulse, sweep runs on untouched.
        gate[2] = 1'b1;
        sample_tick = 1'b1;
        step(); sample_tick = 1'b0; check_slot(0);
        chk("ovr_idle", 32'(overrun), 32'd0);
        step(); check_slot(1);
        chk("ovr_idle2", 32'(overrun), 32'd0);
        sample_tick = 1'b1;
        step(); sample_tick = 1'b0; check_slot(2);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        step(); check_slot(3);
        chk("ovr_end", 32'(overrun), 32'd0);
        step();
        chk("ovr_busy_fall", 32'(busy), 32'd0);
        chk("ovr_valid_fall", 32'(env_valid), 32'd0);

        // Retrigger from RELEASE at 16384, soft then hard.
        gate = '0; gate[0] = 1'b1;
        for (int i = 0; i < 7; i++) sweep();
        gate[0] = 1'b0;
        for (int i = 0; i < 3; i++) sweep();
        chk("rel_16384", 32'(v0_out), 32'd16384);
        gate[0] = 1'b1; hard_retrig = 1'b0;
        sweep(); chk("soft_retrig0", 32'(v0_out), 32'd16384);
        sweep(); chk("soft_retrig1", 32'(v0_out), 32'd49152);
        for (int i = 0; i < 5; i++) sweep();
        gate[0] = 1'b0;
        for (int i = 0; i < 3; i++) sweep();
        chk("rel_16384b", 32'(v0_out), 32'd16384);
        gate[0] = 1'b1; hard_retrig = 1'b1;
        sweep(); chk("hard_retrig0", 32'(v0_out), 32'd0);
        sweep(); chk("hard_retrig1", 32'(v0_out), 32'd32768);

        // Randomized controls and gates, with idle gaps between sweeps.
        for (int i = 0; i < 60; i++) begin
            gate        = VOICES'($urandom);
            a           = CTRL_WIDTH'($urandom_range(0, 15));
            d           = CTRL_WIDTH'($urandom_range(0, 15));
            s           = CTRL_WIDTH'($urandom_range(0, 15));
            r           = CTRL_WIDTH'($urandom_range(0, 15));
            hard_retrig = 1'($urandom_range(0, 1));
            sweep();
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset in the middle of a sweep.
        a = 4'd0; d = 4'd0; s = 4'd8; r = 4'd0; hard_retrig = 1'b0;
        gate = '1;
        sweep();
        gate = '0;
        sample_tick = 1'b1;
        step(); sample_tick = 1'b0; check_slot(0);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(env_valid), 32'd0);
        chk("mid_rst_voice", 32'(env_voice), 32'd0);
        chk("mid_rst_out", 32'(env_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overrun", 32'(overrun), 32'd0);
        model_reset();
        step();
        rst = 1'b0;
        step();
        sample_tick = 1'b1;
        for (int v = 0; v < VOICES; v++) begin
            step();
            sample_tick = 1'b0;
            check_slot(v);
            chk("post_rst_zero", 32'(env_out), 32'd0);
        end
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
